// File: rtl/mat_pkg.sv
// Shared types and constants for the mat_sched block and the 3x3 Q.6 `mat` unit it drives.
package mat_pkg;

    localparam logic [3:0] MAT_ST_IDLE  = 4'b0000;
    localparam logic [3:0] MAT_ST_CLEAR = 4'b0010;
    localparam logic [3:0] MAT_ST_RUN   = 4'b1001;

    localparam int MAT_DW   = 21;
    localparam int MAT_FRAC = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } sched_state_e;

    // IDLE and CAPTURE both leave `mat` parked in its idle code.
    function automatic logic [3:0] mat_code(input sched_state_e s);
        case (s)
            ST_CLEAR: return MAT_ST_CLEAR;
            ST_RUN:   return MAT_ST_RUN;
            default:  return MAT_ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo NREQ.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW:0] cand;

    // Scan offsets 0..NREQ-1 from ptr; ptr is always below NREQ, so one subtraction wraps.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            cand = (cand >= (IW+1)'(NREQ)) ? cand - (IW+1)'(NREQ) : cand;
            if (!any && req[cand[IW-1:0]]) begin
                any                 = 1'b1;
                gnt[cand[IW-1:0]]   = 1'b1;
                idx                 = cand[IW-1:0];
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/mat_sched.sv
// Round-robin scheduler sharing one 3x3 Q.6 `mat` unit between NREQ requesters.
// Optional MAT_SCHED_PERF_EN adds saturating perf_jobs / perf_busy counters.
module mat_sched
    import mat_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = MAT_DW,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*9*DW-1:0] a_in,
    input  logic [NREQ*9*DW-1:0] b_in,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [9*DW-1:0]      m_out,
    output logic                 busy,
    output logic [3:0]           mat_state,
    output logic [9*DW-1:0]      mat_a,
    output logic [9*DW-1:0]      mat_b,
    input  logic                 mat_enable,
    input  logic [9*DW-1:0]      mat_m
`ifdef MAT_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_jobs,
    output logic [31:0]          perf_busy
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int MW = 9 * DW;

    sched_state_e    state_q, state_d;
    logic [IW-1:0]   g_q, g_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]   a_q, a_d;
    logic [MW-1:0]   b_q, b_d;
    logic [MW-1:0]   m_out_q, m_out_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            abort_q, abort_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [3:0]      mat_state_q, mat_state_d;

    logic [NREQ-1:0] arb_gnt_s;
    logic [IW-1:0]   arb_idx_s;
    logic            arb_any_s;

    rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s),
        .any (arb_any_s)
    );

    // Next-state and registered-output logic for the job sequencer.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        m_out_d  = m_out_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    a_d      = a_in[int'(arb_idx_s)*MW +: MW];
                    b_d      = b_in[int'(arb_idx_s)*MW +: MW];
                    g_d      = arb_idx_s;
                    gnt_d    = arb_gnt_s;
                    rr_ptr_d = (arb_idx_s == IW'(NREQ-1)) ? '0 : arb_idx_s + IW'(1);
                    state_d  = ST_CLEAR;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mat_enable) begin
                    state_d = ST_CAPTURE;
                end else if (cnt_q == TW'(TIMEOUT-1)) begin
                    abort_d = 1'b1;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d   = cnt_q + TW'(1);
                end
            end
            ST_CAPTURE: begin
                done_d  = {{(NREQ-1){1'b0}}, 1'b1} << g_q;
                err_d   = abort_q;
                m_out_d = abort_q ? '0 : mat_m;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        mat_state_d = mat_code(state_d);
    end

`ifdef MAT_SCHED_PERF_EN
    logic [31:0] perf_jobs_q, perf_jobs_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    // Occupancy counts every job cycle including its completion cycle; both saturate.
    always_comb begin
        perf_jobs_d = perf_jobs_q;
        perf_busy_d = perf_busy_q;
        if ((|done_d) && !err_d && (perf_jobs_q != 32'hFFFF_FFFF)) begin
            perf_jobs_d = perf_jobs_q + 32'd1;
        end else begin
            perf_jobs_d = perf_jobs_q;
        end
        if ((busy_q || (|done_q)) && (perf_busy_q != 32'hFFFF_FFFF)) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end else begin
            perf_busy_d = perf_busy_q;
        end
    end

    assign perf_jobs = perf_jobs_q;
    assign perf_busy = perf_busy_q;
`endif

    // State and output registers; reset mid-job drops the job without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            m_out_q     <= '0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mat_state_q <= MAT_ST_IDLE;
`ifdef MAT_SCHED_PERF_EN
            perf_jobs_q <= 32'd0;
            perf_busy_q <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_out_q     <= m_out_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mat_state_q <= mat_state_d;
`ifdef MAT_SCHED_PERF_EN
            perf_jobs_q <= perf_jobs_d;
            perf_busy_q <= perf_busy_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign m_out     = m_out_q;
    assign busy      = busy_q;
    assign mat_state = mat_state_q;
    assign mat_a     = a_q;
    assign mat_b     = b_q;

endmodule

// File: tb/tb_mat_sched.sv
// Scoreboard bench for mat_sched with a behavioural `mat` model (load + 8 shifts + flag).
module tb_mat_sched;
    import mat_pkg::*;

    localparam int NREQ    = 4;
    localparam int DW      = 21;
    localparam int TIMEOUT = 16;
    localparam int MW      = 9 * DW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*MW-1:0]   a_in = '0;
    logic [NREQ*MW-1:0]   b_in = '0;
    logic [NREQ-1:0]      gnt, done;
    logic                 err, busy, mat_enable;
    logic [MW-1:0]        m_out, mat_a, mat_b, mat_m;
    logic [3:0]           mat_state;
`ifdef MAT_SCHED_PERF_EN
    logic [31:0]          perf_jobs, perf_busy;
`endif

    mat_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .err(err), .m_out(m_out), .busy(busy),
        .mat_state(mat_state), .mat_a(mat_a), .mat_b(mat_b),
        .mat_enable(mat_enable), .mat_m(mat_m)
`ifdef MAT_SCHED_PERF_EN
        , .perf_jobs(perf_jobs), .perf_busy(perf_busy)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // `mat` model: cleared by CLEAR, counts RUN cycles, flags after 9 of them.
    logic [4:0] mcnt = 5'd0;
    logic       en_kill = 1'b0;
    always @(posedge clk) begin
        if (mat_state == MAT_ST_CLEAR) mcnt <= 5'd0;
        else if (mat_state == MAT_ST_RUN && mcnt < 5'd15) mcnt <= mcnt + 5'd1;
    end
    assign mat_enable = !en_kill && (mcnt >= 5'd9);

    always_comb begin
        longint acc;
        logic signed [DW-1:0] ea, eb;
        mat_m = '0;
        acc = 0;
        ea = '0;
        eb = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                acc = 0;
                for (int j = 0; j < 3; j++) begin
                    ea = mat_a[(r*3+j)*DW +: DW];
                    eb = mat_b[(j*3+c)*DW +: DW];
                    acc = acc + longint'(ea) * longint'(eb);
                end
                mat_m[(r*3+c)*DW +: DW] = DW'(acc >>> MAT_FRAC);
            end
        end
    end

    typedef struct { int idx; int cyc; } gexp_t;
    typedef struct { int idx; int cyc; logic [MW-1:0] m; logic err; } dexp_t;
    gexp_t gq[$];
    dexp_t dq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Hand-derived products: requesters 0..2 use diag((i+1)*64) x B, requester 3 uses all-64 A.
    function automatic logic [MW-1:0] exp_res(input int i);
        logic [MW-1:0] v;
        int e;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (i == 3) e = 64 * (3*c + 9);
                else        e = (i + 1) * 64 * (r*3 + c);
                v[(r*3+c)*DW +: DW] = DW'(e);
            end
        end
        return v;
    endfunction

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 9; k++) begin
                if (i == 3) a_in[(i*9+k)*DW +: DW] = DW'(64);
                else        a_in[(i*9+k)*DW +: DW] = (k/3 == k%3) ? DW'((i+1)*64) : DW'(0);
                b_in[(i*9+k)*DW +: DW] = DW'(k*64);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a completion.
    always @(negedge clk) begin
        gexp_t ge;
        dexp_t de;
        if (!rst) begin
            if (gnt != '0) begin
                if (gq.size() == 0) chk("gnt_unexpected", MW'(gnt), '0);
                else begin
                    ge = gq.pop_front();
                    chk("gnt_onehot", MW'(gnt), MW'(1) << ge.idx);
                    chk("gnt_cycle", MW'(cyc), MW'(ge.cyc));
                end
            end
            if (done != '0) begin
                if (dq.size() == 0) chk("done_unexpected", MW'(done), '0);
                else begin
                    de = dq.pop_front();
                    chk("done_onehot", MW'(done), MW'(1) << de.idx);
                    chk("done_cycle", MW'(cyc), MW'(de.cyc));
                    chk("m_out", m_out, de.m);
                    chk("err", MW'(err), MW'(de.err));
                end
            end
        end
    end

    task automatic issue(input int idx, input logic kill);
        int n;
        dexp_t de;
        n = cyc + 1;
        req[idx] = 1'b1;
        gq.push_back('{idx: idx, cyc: n});
        de.idx = idx;
        de.cyc = kill ? n + TIMEOUT + 2 : n + 12;
        de.m   = kill ? '0 : exp_res(idx);
        de.err = kill;
        dq.push_back(de);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic run_until_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            req = req & ~gnt;
            if (req == '0 && !busy && gnt == '0 && dq.size() == 0) ok = 1'b1;
        end
        chk("idle_wait", MW'(ok), MW'(1));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gnt"},       MW'(gnt),       '0);
        chk({tag, "_done"},      MW'(done),      '0);
        chk({tag, "_err"},       MW'(err),       '0);
        chk({tag, "_m_out"},     m_out,          '0);
        chk({tag, "_busy"},      MW'(busy),      '0);
        chk({tag, "_mat_state"}, MW'(mat_state), '0);
        chk({tag, "_mat_a"},     mat_a,          '0);
        chk({tag, "_mat_b"},     mat_b,          '0);
    endtask

    initial begin
        int n;
        int gseen;
        logic [MW-1:0] hold_a;
        dexp_t de;

        set_ops();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // Single job; operands are clobbered after the grant to prove they were latched.
        n = cyc + 1;
        issue(0, 1'b0);
        hold_a = a_in[0 +: MW];
        wait_cyc(n);
        req[0] = 1'b0;
        a_in[0 +: MW] = {MW{1'b1}};
        chk("clear_code", MW'(mat_state), MW'(MAT_ST_CLEAR));
        chk("busy_clear", MW'(busy), MW'(1));
        wait_cyc(n + 1);
        chk("run_code", MW'(mat_state), MW'(MAT_ST_RUN));
        chk("mat_a_latched", mat_a, hold_a);
        chk("mat_b_latched", mat_b, b_in[0 +: MW]);
        run_until_idle(40);
        set_ops();
        @(negedge clk);
        chk("m_out_held", m_out, exp_res(0));

        // Round robin from a fresh pointer with all requests held.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = cyc + 1;
        req = '1;
        for (int i = 0; i < 5; i++) begin
            gq.push_back('{idx: i % 4, cyc: n + 13*i});
            de.idx = i % 4; de.cyc = n + 13*i + 12; de.m = exp_res(i % 4); de.err = 1'b0;
            dq.push_back(de);
        end
        gseen = 0;
        for (int i = 0; i < 100 && gseen < 5; i++) begin
            @(negedge clk);
            if (gnt != '0) gseen++;
        end
        req = '0;
        run_until_idle(40);

        // Fairness: after serving 2 the pointer sits at 3, so 1 wins over 2.
        issue(2, 1'b0);
        run_until_idle(40);
        n = cyc + 1;
        req[1] = 1'b1;
        req[2] = 1'b1;
        gq.push_back('{idx: 1, cyc: n});
        gq.push_back('{idx: 2, cyc: n + 13});
        de.idx = 1; de.cyc = n + 12; de.m = exp_res(1); de.err = 1'b0; dq.push_back(de);
        de.idx = 2; de.cyc = n + 25; de.m = exp_res(2); de.err = 1'b0; dq.push_back(de);
        run_until_idle(60);

        // Timeout with the `mat` flag held low.
        en_kill = 1'b1;
        issue(3, 1'b1);
        run_until_idle(60);
        chk("timeout_busy", MW'(busy), '0);
        chk("timeout_state", MW'(mat_state), MW'(MAT_ST_IDLE));
        en_kill = 1'b0;

        // Reset in the middle of RUN: no done, then a clean job.
        n = cyc + 1;
        req[0] = 1'b1;
        gq.push_back('{idx: 0, cyc: n});
        wait_cyc(n);
        req[0] = 1'b0;
        wait_cyc(n + 5);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrun");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(0, 1'b0);
        run_until_idle(40);

        chk("gnt_queue_empty", MW'(gq.size()), '0);
        chk("done_queue_empty", MW'(dq.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
